sdc_reg_sequencer: RTL and testbench

SDC_REG_SEQUENCER -- requirements
Module: sdc_reg_sequencer

---
 rtl/sdc_reg_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_sdc_reg_sequencer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdc_reg_sequencer.sv
// sdc_reg_sequencer
//   Queues register-bus operations (WRITE / WAIT / POLL) in a small FIFO and
//   plays them out one at a time onto a simple register controller bus.
//
// Parameters
//   ADDR_W  register-bus address width
//   DATA_W  register-bus data width
//   DEPTH   op FIFO entries (power of two, >= 2)
//   CNT_W   delay / poll-iteration counter width
//
// Ports
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   op_valid/op_ready           op handshake; op_ready = !full & !err
//   op_code                     0=WRITE 1=WAIT 2=POLL 3=reserved (WAIT, count 0)
//   op_addr/op_data/op_mask     address, write data or compare value, compare mask
//   op_count                    WAIT delay cycles / POLL iteration limit
//   bus_addr/bus_wdata/bus_we   to controller; addr/data hold their last value
//   bus_rdata                   from controller, sampled during poll compare
//   busy                        FIFO non-empty or an op in flight
//   done                        one-cycle pulse per completed op
//   err / err_clr               sticky poll timeout flag and its clear
//   fifo_level                  number of stored ops
//
// Configuration
//   SDC_SEQ_POLL_TIMEOUT_EN     when defined, POLL gives up after op_count
//                               mismatched iterations (0 = unlimited), sets err
//                               and flushes the FIFO. When undefined, POLL
//                               iterates until match and err is tied to 0.

module sdc_reg_sequencer #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid,
    output logic                       op_ready,
    input  logic [1:0]                 op_code,
    input  logic [ADDR_W-1:0]          op_addr,
    input  logic [DATA_W-1:0]          op_data,
    input  logic [DATA_W-1:0]          op_mask,
    input  logic [CNT_W-1:0]           op_count,
    output logic [ADDR_W-1:0]          bus_addr,
    output logic [DATA_W-1:0]          bus_wdata,
    output logic                       bus_we,
    input  logic [DATA_W-1:0]          bus_rdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    input  logic                       err_clr,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_WAIT  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_code_e;

    typedef enum logic [2:0] {
        IDLE,
        W_SETUP,
        W_STROBE,
        DELAY,
        P_ADDR,
        P_CMP
    } state_e;

    typedef struct packed {
        op_code_e            code;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
        logic [DATA_W-1:0]   mask;
        logic [CNT_W-1:0]    count;
    } op_t;

    // ------------------------------------------------------------------
    // Op FIFO
    // ------------------------------------------------------------------
    op_t              fifo_mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;

    op_t  op_in;
    op_t  head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic flush;

    state_e state_q, state_d;

    assign op_in = '{code:  op_code_e'(op_code),
                     addr:  op_addr,
                     data:  op_data,
                     mask:  op_mask,
                     count: op_count};

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign op_ready = !full && !err;
    assign push     = op_valid && op_ready;
    assign pop      = (state_q == IDLE) && !empty;
    assign head     = fifo_mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= op_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic [DATA_W-1:0] cmp_q,       cmp_d;
    logic [DATA_W-1:0] mask_q,      mask_d;
    logic [ADDR_W-1:0] bus_addr_q,  bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              done_q,      done_d;
    logic              timeout;
    logic              match;

    assign match = ((bus_rdata & mask_q) == (cmp_q & mask_q));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cmp_d       = cmp_q;
        mask_d      = mask_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        done_d      = 1'b0;
        timeout     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    // All op fields are captured here so later FIFO traffic
                    // cannot disturb the op in flight.
                    unique case (head.code)
                        OP_WRITE: begin
                            bus_addr_d  = head.addr;
                            bus_wdata_d = head.data;
                            state_d     = W_SETUP;
                        end
                        OP_WAIT: begin
                            cnt_d   = head.count;
                            state_d = DELAY;
                        end
                        OP_POLL: begin
                            bus_addr_d = head.addr;
                            cmp_d      = head.data;
                            mask_d     = head.mask;
                            cnt_d      = head.count;
                            state_d    = P_ADDR;
                        end
                        default: begin
                            cnt_d   = '0;
                            state_d = DELAY;
                        end
                    endcase
                end
            end

            W_SETUP: begin
                state_d = W_STROBE;
            end

            W_STROBE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end

            DELAY: begin
                // Leaving when the count would reach zero gives N cycles
                // for N >= 1 and a single cycle for N == 0.
                if (cnt_q <= CNT_W'(1)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            P_ADDR: begin
                state_d = P_CMP;
            end

            P_CMP: begin
                if (match) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
`ifdef SDC_SEQ_POLL_TIMEOUT_EN
                    // cnt_q holds iterations left; zero means unlimited.
                    if (cnt_q == CNT_W'(1)) begin
                        timeout = 1'b1;
                        state_d = IDLE;
                    end else begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                        state_d = P_ADDR;
                    end
`else
                    state_d = P_ADDR;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmp_q       <= '0;
            mask_q      <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmp_q       <= cmp_d;
            mask_q      <= mask_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            done_q      <= done_d;
        end
    end

    assign flush = timeout;

    // ------------------------------------------------------------------
    // Error flag
    // ------------------------------------------------------------------
`ifdef SDC_SEQ_POLL_TIMEOUT_EN
    logic err_q;

    // A timeout in the same cycle as err_clr wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_we     = (state_q == W_STROBE);
    assign done       = done_q;
    assign busy       = !empty || (state_q != IDLE);
    assign fifo_level = level_q;

endmodule

// File: tb/tb_sdc_reg_sequencer.sv
// tb_sdc_reg_sequencer
//   Self-checking bench for sdc_reg_sequencer. A small register-file model
//   answers bus reads (with an override for stuck/forced read data), a
//   scoreboard queue holds the bus writes expected from the pushed ops, and a
//   table of single ops is followed by hand-written multi-cycle sequences.

module tb_sdc_reg_sequencer;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);

    localparam logic [1:0] C_WRITE = 2'd0;
    localparam logic [1:0] C_WAIT  = 2'd1;
    localparam logic [1:0] C_POLL  = 2'd2;
    localparam logic [1:0] C_RSVD  = 2'd3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              op_valid = 1'b0;
    logic              op_ready;
    logic [1:0]        op_code = '0;
    logic [ADDR_W-1:0] op_addr = '0;
    logic [DATA_W-1:0] op_data = '0;
    logic [DATA_W-1:0] op_mask = '0;
    logic [CNT_W-1:0]  op_count = '0;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_we;
    logic [DATA_W-1:0] bus_rdata;
    logic              busy;
    logic              done;
    logic              err;
    logic              err_clr = 1'b0;
    logic [LVL_W-1:0]  fifo_level;

    sdc_reg_sequencer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .op_addr    (op_addr),
        .op_data    (op_data),
        .op_mask    (op_mask),
        .op_count   (op_count),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_we     (bus_we),
        .bus_rdata  (bus_rdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .err_clr    (err_clr),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Register-file model of the controller, with a read-data override.
    logic [DATA_W-1:0] regmem [128];
    logic              force_en  = 1'b0;
    logic [DATA_W-1:0] force_val = '0;

    assign bus_rdata = force_en ? force_val : regmem[bus_addr];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 128; i++) regmem[i] <= '0;
        end else if (bus_we) begin
            regmem[bus_addr] <= bus_wdata;
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc++;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard of expected bus writes and done pulses.
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    wr_t         exp_wr_q [$];
    int unsigned exp_done = 0;
    int unsigned done_cnt = 0;
    logic        we_prev  = 1'b0;

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_t e;
        e.a = a;
        e.d = d;
        exp_wr_q.push_back(e);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (bus_we) begin
            check("we_single_cycle", we_prev, 1'b0);
            if (exp_wr_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", bus_addr, bus_wdata);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", bus_addr, e.a);
                check("wr_data", bus_wdata, e.d);
            end
        end
        we_prev = bus_we;
        if (done) done_cnt++;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push_op(input logic [1:0] c, input logic [ADDR_W-1:0] a,
                           input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m,
                           input logic [CNT_W-1:0] n);
        int unsigned guard;
        guard    = 0;
        op_code  = c;
        op_addr  = a;
        op_data  = d;
        op_mask  = m;
        op_count = n;
        op_valid = 1'b1;
        while (!op_ready && guard < 3000) begin
            step();
            guard++;
        end
        if (!op_ready) begin
            n_cmp++;
            n_fail++;
            $display("FAIL push_timeout: got op_ready 0 expected 1");
        end
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned maxc);
        int unsigned guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (busy && guard < maxc);
        check("idle_reached", busy, 1'b0);
    endtask

    typedef struct {
        logic [1:0]        code;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] mask;
        logic [CNT_W-1:0]  count;
        logic              exp_we;
        int unsigned       exp_cycles;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_wdata;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int unsigned c0;
        int unsigned cyc_pop;
        int unsigned dly;
        int unsigned guard;
        int unsigned d0;
        logic        busy_dropped;
        logic        seen;
        logic [ADDR_W-1:0] prev_a;
        logic [DATA_W-1:0] prev_d;
        logic              prev_we;

        //             code     addr   data   mask   count  we    cyc  bus_addr wdata
        vecs[0] = '{C_WRITE, 7'h24, 8'h02, 8'h00, 16'd0,  1'b1, 3, 7'h24, 8'h02};
        vecs[1] = '{C_WRITE, 7'h10, 8'hA5, 8'h00, 16'd0,  1'b1, 3, 7'h10, 8'hA5};
        vecs[2] = '{C_WAIT,  7'h33, 8'h44, 8'h00, 16'd5,  1'b0, 6, 7'h10, 8'hA5};
        vecs[3] = '{C_POLL,  7'h10, 8'hA3, 8'hF0, 16'd4,  1'b0, 3, 7'h10, 8'hA5};
        vecs[4] = '{C_WRITE, 7'h7F, 8'hFF, 8'h00, 16'd0,  1'b1, 3, 7'h7F, 8'hFF};
        vecs[5] = '{C_RSVD,  7'h11, 8'h22, 8'h00, 16'd50, 1'b0, 2, 7'h7F, 8'hFF};
        vecs[6] = '{C_POLL,  7'h24, 8'h02, 8'hFF, 16'd0,  1'b0, 3, 7'h24, 8'hFF};
        vecs[7] = '{C_WRITE, 7'h00, 8'h00, 8'h00, 16'd0,  1'b1, 3, 7'h00, 8'h00};
        vecs[8] = '{C_WAIT,  7'h01, 8'h01, 8'h00, 16'd0,  1'b0, 2, 7'h00, 8'h00};
        vecs[9] = '{C_WRITE, 7'h55, 8'h3C, 8'h00, 16'd0,  1'b1, 3, 7'h55, 8'h3C};

        // Reset state
        rst = 1'b1;
        repeat (3) step();
        check("rst_level",  fifo_level, 0);
        check("rst_addr",   bus_addr, 0);
        check("rst_wdata",  bus_wdata, 0);
        check("rst_we",     bus_we, 0);
        check("rst_done",   done, 0);
        check("rst_err",    err, 0);
        check("rst_busy",   busy, 0);
        rst = 1'b0;
        step();
        check("rst_release_ready", op_ready, 1);

        // Single-op vectors
        for (int i = 0; i < 10; i++) begin
            push_op(vecs[i].code, vecs[i].addr, vecs[i].data, vecs[i].mask, vecs[i].count);
            c0 = cyc;
            if (vecs[i].exp_we) expect_wr(vecs[i].addr, vecs[i].data);
            exp_done++;
            wait_idle(100);
            check($sformatf("vec%0d_cycles", i), cyc - c0, vecs[i].exp_cycles);
            check($sformatf("vec%0d_bus_addr", i), bus_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d_bus_wdata", i), bus_wdata, vecs[i].exp_wdata);
            check($sformatf("vec%0d_done_cnt", i), done_cnt, exp_done);
        end

        // WRITE strobe shape: setup cycle, one strobe cycle, done after
        push_op(C_WRITE, 7'h24, 8'h02, 8'h00, 16'd0);
        expect_wr(7'h24, 8'h02);
        exp_done++;
        prev_a  = bus_addr;
        prev_d  = bus_wdata;
        prev_we = bus_we;
        guard   = 0;
        while (!bus_we && guard < 20) begin
            prev_a  = bus_addr;
            prev_d  = bus_wdata;
            prev_we = bus_we;
            step();
            guard++;
        end
        check("strobe_seen",       bus_we, 1);
        check("setup_addr",        prev_a, 7'h24);
        check("setup_wdata",       prev_d, 8'h02);
        check("setup_we_low",      prev_we, 0);
        step();
        check("strobe_one_cycle",  bus_we, 0);
        check("done_after_strobe", done, 1);
        wait_idle(20);

        // Long WAIT followed by WRITE
        push_op(C_WAIT, 7'h00, 8'h00, 8'h00, 16'd1000);
        cyc_pop = cyc + 1;
        push_op(C_WRITE, 7'h00, 8'h00, 8'h00, 16'd0);
        expect_wr(7'h00, 8'h00);
        exp_done += 2;
        check("push_pop_level", fifo_level, 1);
        busy_dropped = 1'b0;
        guard        = 0;
        while (!bus_we && guard < 1200) begin
            step();
            if (!busy) busy_dropped = 1'b1;
            guard++;
        end
        dly = cyc - cyc_pop;
        check("wait_strobe_in_window", (dly >= 998 && dly <= 1002), 1);
        check("wait_busy_held", busy_dropped, 0);
        wait_idle(20);
        check("wait_done_cnt", done_cnt, exp_done);

        // POLL with read data held low for 10 cycles, then matching
        force_en  = 1'b1;
        force_val = 8'h00;
        push_op(C_POLL, 7'h3C, 8'h01, 8'h01, 16'd0);
        push_op(C_WRITE, 7'h3D, 8'h77, 8'h00, 16'd0);
        expect_wr(7'h3D, 8'h77);
        exp_done += 2;
        d0 = done_cnt;
        repeat (10) step();
        check("poll_no_done",  done_cnt, d0);
        check("poll_busy",     busy, 1);
        check("poll_bus_addr", bus_addr, 7'h3C);
        check("poll_level",    fifo_level, 1);
        force_val = 8'h01;
        wait_idle(50);
        check("poll_done_cnt", done_cnt, exp_done);
        check("poll_no_err",   err, 0);

`ifdef SDC_SEQ_POLL_TIMEOUT_EN
        // POLL timeout: flush queued ops, block pushes until err_clr
        force_val = 8'h00;
        push_op(C_WAIT, 7'h00, 8'h00, 8'h00, 16'd20);
        c0 = cyc;
        push_op(C_POLL, 7'h20, 8'h01, 8'hFF, 16'd3);
        for (int i = 0; i < 4; i++) push_op(C_WRITE, 7'(8'h40 + i), 8'(i), 8'h00, 16'd0);
        exp_done++;
        check("flush_pre_level", fifo_level, 5);
        guard = 0;
        while (!err && guard < 200) begin
            step();
            guard++;
        end
        check("timeout_err",    err, 1);
        check("timeout_cycles", cyc - c0, 28);
        check("flush_level",    fifo_level, 0);
        check("flush_ready",    op_ready, 0);
        check("flush_busy",     busy, 0);
        check("timeout_no_done", done_cnt, exp_done);
        repeat (3) step();
        check("err_sticky",       err, 1);
        check("err_ready_held",   op_ready, 0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared",      err, 0);
        check("err_clear_ready",  op_ready, 1);

        // Timeout coinciding with err_clr still sets err
        err_clr = 1'b1;
        push_op(C_POLL, 7'h21, 8'h01, 8'hFF, 16'd2);
        seen  = 1'b0;
        guard = 0;
        while (!seen && guard < 50) begin
            step();
            if (err) seen = 1'b1;
            guard++;
        end
        check("timeout_beats_clr", seen, 1);
        step();
        check("clr_after_timeout", err, 0);
        err_clr = 1'b0;
        check("coincide_level", fifo_level, 0);
`else
        // Without timeout support POLL ignores op_count and err stays 0
        force_val = 8'h00;
        push_op(C_POLL, 7'h20, 8'h01, 8'hFF, 16'd3);
        exp_done++;
        repeat (20) step();
        check("no_to_err",   err, 0);
        check("no_to_busy",  busy, 1);
        check("no_to_ready", op_ready, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("no_to_err_clr", err, 0);
        force_val = 8'h01;
        wait_idle(50);
        check("no_to_done_cnt", done_cnt, exp_done);
`endif
        force_en = 1'b0;

        // Fill the FIFO behind a long WAIT
        push_op(C_WAIT, 7'h00, 8'h00, 8'h00, 16'd100);
        exp_done++;
        for (int i = 0; i < 15; i++) push_op(C_WAIT, 7'h00, 8'h00, 8'h00, 16'd0);
        push_op(C_WRITE, 7'h66, 8'h99, 8'h00, 16'd0);
        expect_wr(7'h66, 8'h99);
        exp_done += 16;
        check("full_level", fifo_level, 16);
        check("full_ready", op_ready, 0);
        op_code  = C_WRITE;
        op_addr  = 7'h67;
        op_data  = 8'h11;
        op_valid = 1'b1;
        repeat (3) step();
        op_valid = 1'b0;
        check("full_push_blocked", fifo_level, 16);
        guard = 0;
        while (fifo_level == LVL_W'(16) && guard < 200) begin
            step();
            guard++;
        end
        check("first_pop_level", fifo_level, 15);
        check("first_pop_ready", op_ready, 1);
        wait_idle(200);
        check("drain_done_cnt", done_cnt, exp_done);

        // Reset during the write strobe
        push_op(C_WAIT, 7'h00, 8'h00, 8'h00, 16'd10);
        push_op(C_WRITE, 7'h12, 8'h34, 8'h00, 16'd0);
        push_op(C_WRITE, 7'h56, 8'h78, 8'h00, 16'd0);
        expect_wr(7'h12, 8'h34);
        exp_done++;
        guard = 0;
        while (!bus_we && guard < 100) begin
            step();
            guard++;
        end
        check("rst_strobe_seen", bus_we, 1);
        rst = 1'b1;
        step();
        check("rst_abort_we",    bus_we, 0);
        check("rst_abort_level", fifo_level, 0);
        check("rst_abort_done",  done, 0);
        check("rst_abort_busy",  busy, 0);
        check("rst_abort_addr",  bus_addr, 0);
        rst = 1'b0;
        repeat (3) step();
        check("rst_abort_no_done", done_cnt, exp_done);
        check("rst_abort_ready",   op_ready, 1);

        check("sb_empty",   exp_wr_q.size(), 0);
        check("done_total", done_cnt, exp_done);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
